// File: rtl/tri_scan_pkg.sv
// Shared types, state encoding and default geometry/latency constants
// for the triangle pixel scanner and its coordinate delay line.
package tri_scan_pkg;

  localparam int COORD_WIDTH_DEF  = 32;
  localparam int SCREEN_W_DEF     = 320;
  localparam int SCREEN_H_DEF     = 180;
  localparam int BARY_LATENCY_DEF = 13;

  typedef logic signed [COORD_WIDTH_DEF/2-1:0] coord_t;
  typedef coord_t [2:0] vec3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BBOX,
    ST_BARY_RST,
    ST_BARY_INIT,
    ST_WAIT_INIT,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } st_e;

endpackage

// File: rtl/pix_delay_line.sv
// Fixed-depth shift register carrying {valid, x, y} so pixel coordinates
// leave aligned with the barycentric result; synchronous clear.
module pix_delay_line #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 33
) (
  input  logic             clk_in,
  input  logic             clr_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (clr_in) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/tri_pixel_scanner.sv
// Triangle setup and raster pixel issue ahead of the barycentric unit.
// Optional TRI_PIXEL_SCANNER_PERF_EN adds a per-triangle pix_count output.
//
// state     | meaning
// IDLE      | ready for a triangle
// BBOX      | clamp bounding box from registered vertices
// BARY_RST  | reset pulse to barycentric unit
// BARY_INIT | init pulse to barycentric unit
// WAIT_INIT | wait for init_done / init_failed
// SCAN      | issue one pixel per unstalled cycle
// DRAIN     | let the barycentric pipeline empty
// DONE      | tri_done pulse
module tri_pixel_scanner
  import tri_scan_pkg::*;
#(
  parameter int COORD_WIDTH  = COORD_WIDTH_DEF,
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int BARY_LATENCY = BARY_LATENCY_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         tri_valid,
  input  logic [2:0][COORD_WIDTH/2-1:0] tri_a,
  input  logic [2:0][COORD_WIDTH/2-1:0] tri_b,
  input  logic [2:0][COORD_WIDTH/2-1:0] tri_c,
  output logic                         tri_ready,
  input  logic                         stall_in,
  output logic                         bary_rst,
  output logic                         bary_init,
  output logic [2:0][COORD_WIDTH/2-1:0] bary_a,
  output logic [2:0][COORD_WIDTH/2-1:0] bary_b,
  output logic [2:0][COORD_WIDTH/2-1:0] bary_c,
  input  logic                         bary_init_done,
  input  logic                         bary_init_failed,
  output logic [2:0][COORD_WIDTH/2-1:0] bary_p,
  output logic                         bary_valid,
  output logic [COORD_WIDTH/2-1:0]     pix_x,
  output logic [COORD_WIDTH/2-1:0]     pix_y,
  output logic                         pix_valid,
  output logic                         tri_done,
  output logic                         tri_skipped
`ifdef TRI_PIXEL_SCANNER_PERF_EN
  ,
  output logic [31:0]                  pix_count
`endif
);

  localparam int CW    = COORD_WIDTH / 2;
  localparam int CNT_W = (BARY_LATENCY > 1) ? $clog2(BARY_LATENCY) : 1;
  localparam logic signed [CW-1:0] X_HI = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] Y_HI = CW'(SCREEN_H - 1);

  function automatic logic signed [CW-1:0] smin(input logic signed [CW-1:0] p,
                                                input logic signed [CW-1:0] q);
    return (p < q) ? p : q;
  endfunction

  function automatic logic signed [CW-1:0] smax(input logic signed [CW-1:0] p,
                                                input logic signed [CW-1:0] q);
    return (p > q) ? p : q;
  endfunction

  st_e state_q, state_d;

  logic [2:0][CW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
  logic signed [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     drain_q, drain_d;
  logic                 skipped_q, skipped_d;

  logic signed [CW-1:0] ax, ay, bx, by, cx, cy;
  logic signed [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic                 bb_empty, issue, last_pix;
  logic                 unused_z;

  assign unused_z = ^{tri_a[2], tri_b[2], tri_c[2]};

  assign ax = $signed(a_q[0]);
  assign ay = $signed(a_q[1]);
  assign bx = $signed(b_q[0]);
  assign by = $signed(b_q[1]);
  assign cx = $signed(c_q[0]);
  assign cy = $signed(c_q[1]);

  assign bb_xmin  = smax(smin(smin(ax, bx), cx), '0);
  assign bb_xmax  = smin(smax(smax(ax, bx), cx), X_HI);
  assign bb_ymin  = smax(smin(smin(ay, by), cy), '0);
  assign bb_ymax  = smin(smax(smax(ay, by), cy), Y_HI);
  assign bb_empty = (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

  assign issue    = (state_q == ST_SCAN) && !stall_in;
  assign last_pix = (x_q == xmax_q) && (y_q == ymax_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (tri_valid) state_d = ST_BBOX;
      ST_BBOX:      state_d = bb_empty ? ST_DONE : ST_BARY_RST;
      ST_BARY_RST:  state_d = ST_BARY_INIT;
      ST_BARY_INIT: state_d = ST_WAIT_INIT;
      ST_WAIT_INIT: begin
        if (bary_init_failed)    state_d = ST_DONE;
        else if (bary_init_done) state_d = ST_SCAN;
      end
      ST_SCAN:      if (issue && last_pix) state_d = ST_DRAIN;
      ST_DRAIN:     if (drain_q == '0) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tri_ready   = 1'b0;
    bary_rst    = 1'b0;
    bary_init   = 1'b0;
    bary_valid  = 1'b0;
    tri_done    = 1'b0;
    tri_skipped = 1'b0;
    case (state_q)
      ST_IDLE:      tri_ready = !rst_in;
      ST_BARY_RST:  bary_rst = 1'b1;
      ST_BARY_INIT: bary_init = 1'b1;
      ST_SCAN:      bary_valid = !stall_in;
      ST_DONE: begin
        tri_done    = 1'b1;
        tri_skipped = skipped_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymax_d    = ymax_q;
    x_d       = x_q;
    y_d       = y_q;
    drain_d   = drain_q;
    skipped_d = skipped_q;
    case (state_q)
      ST_IDLE: begin
        if (tri_valid) begin
          a_d       = {{CW{1'b0}}, tri_a[1], tri_a[0]};
          b_d       = {{CW{1'b0}}, tri_b[1], tri_b[0]};
          c_d       = {{CW{1'b0}}, tri_c[1], tri_c[0]};
          skipped_d = 1'b0;
        end
      end
      ST_BBOX: begin
        xmin_d    = bb_xmin;
        xmax_d    = bb_xmax;
        ymax_d    = bb_ymax;
        x_d       = bb_xmin;
        y_d       = bb_ymin;
        skipped_d = bb_empty;
      end
      ST_WAIT_INIT: if (bary_init_failed) skipped_d = 1'b1;
      ST_SCAN: begin
        if (issue) begin
          if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
          if (last_pix) drain_d = CNT_W'(BARY_LATENCY - 1);
        end
      end
      ST_DRAIN: if (drain_q != '0) drain_d = drain_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      xmin_q    <= '0;
      xmax_q    <= '0;
      ymax_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      drain_q   <= '0;
      skipped_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      xmin_q    <= xmin_d;
      xmax_q    <= xmax_d;
      ymax_q    <= ymax_d;
      x_q       <= x_d;
      y_q       <= y_d;
      drain_q   <= drain_d;
      skipped_q <= skipped_d;
    end
  end

  assign bary_a = a_q;
  assign bary_b = b_q;
  assign bary_c = c_q;
  assign bary_p = {{CW{1'b0}}, y_q, x_q};

  // Runs every cycle, stalled or not: the barycentric pipeline never waits.
  logic [2*CW:0] dly_in, dly_out;
  assign dly_in = {bary_valid, x_q, y_q};

  pix_delay_line #(
    .DEPTH(BARY_LATENCY),
    .WIDTH(2*CW + 1)
  ) u_pix_delay_line (
    .clk_in(clk_in),
    .clr_in(rst_in),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign {pix_valid, pix_x, pix_y} = dly_out;

`ifdef TRI_PIXEL_SCANNER_PERF_EN
  logic [31:0] pix_count_q, pix_count_d;

  always_comb begin
    pix_count_d = pix_count_q;
    if (state_q == ST_IDLE && tri_valid) pix_count_d = '0;
    else if (issue)                      pix_count_d = pix_count_q + 32'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) pix_count_q <= '0;
    else        pix_count_q <= pix_count_d;
  end

  assign pix_count = pix_count_q;
`endif

endmodule

// File: doc/tri_pixel_scanner.md
# tri_pixel_scanner

Triangle setup and pixel-issue stage directly upstream of the barycentric unit. It accepts one screen-space triangle at a time, computes a clamped bounding box, and resets and initialises the barycentric unit. It then streams every pixel of the box into the unit, one per cycle. Alongside, it delays each pixel's screen coordinate so it leaves the block aligned with the unit's u/v/w result for that pixel, ready for the attribute interpolator downstream.

## Interface
Parameters:
- COORD_WIDTH, 32, matches the barycentric unit; vertex/pixel components are signed COORD_WIDTH/2 bits
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 180, screen height in pixels
- BARY_LATENCY, 13, cycles from bary_valid/bary_p to the matching barycentric valid_out

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; one clock; reset is synchronous and active-high
- tri_valid  in  1  triangle offered
- tri_a, tri_b, tri_c  in  [2:0][COORD_WIDTH/2-1:0] signed  vertices; [0]=x, [1]=y, [2]=z (z ignored)
- tri_ready  out  1  high only in IDLE
- stall_in  in  1  downstream busy; suppresses pixel issue
- bary_rst  out  1  one-cycle reset pulse to barycentric unit
- bary_init  out  1  one-cycle init pulse
- bary_a, bary_b, bary_c  out  [2:0][COORD_WIDTH/2-1:0]  registered vertices, z forced to 0, held stable from BARY_RST until DONE
- bary_init_done, bary_init_failed  in  1  from barycentric unit
- bary_p  out  [2:0][COORD_WIDTH/2-1:0]  pixel (x, y, 0)
- bary_valid  out  1  bary_p valid this cycle
- pix_x, pix_y  out  COORD_WIDTH/2  coordinate aligned with u/v/w
- pix_valid  out  1  delayed bary_valid
- tri_done  out  1  one-cycle pulse, triangle finished
- tri_skipped  out  1  qualifies tri_done: no pixels issued (off-screen or degenerate)

## Operation
- States:
  - IDLE → BBOX on tri_valid&&tri_ready; vertices are registered.
  - BBOX → BARY_RST, or → DONE with skipped if the box is empty.
  - BARY_RST → BARY_INIT → WAIT_INIT.
  - WAIT_INIT → SCAN on bary_init_done, or → DONE with skipped on bary_init_failed. Failed has priority if both are asserted in the same cycle.
  - SCAN → DRAIN after issuing (xmax, ymax).
  - DRAIN → DONE after BARY_LATENCY cycles.
  - DONE → IDLE.
- BBOX rules:
  - xmin = max(min(ax,bx,cx), 0); xmax = min(max(ax,bx,cx), SCREEN_W-1); y likewise with SCREEN_H-1. All comparisons signed.
  - The box is empty if xmin>xmax or ymin>ymax. In that case bary_rst/bary_init are never asserted.
- bary_rst exists because the barycentric unit never leaves its ready state except via reset.
- SCAN, raster order (x fastest, starting at (xmin, ymin)):
  - Each cycle with !stall_in: bary_p=(x,y,0), bary_valid=1, then advance.
  - At x==xmax: x←xmin, y←y+1.
  - While stall_in is high: bary_valid=0 and x/y hold.
- The coordinate delay line shifts every cycle regardless of stall_in. The barycentric pipeline cannot stall, so stall_in only throttles issue.
- rst_in mid-triangle aborts the triangle: state←IDLE, delay line cleared, no tri_done.

## Timing
- Reset values: tri_ready=0 during reset, 1 in the first cycle after it; every other output 0.
- Accept at cycle T: BBOX at T+1, bary_rst=1 at T+2, bary_init=1 at T+3.
- First bary_valid is in the cycle after bary_init_done is sampled high.
- pix_valid/pix_x/pix_y equal bary_valid/x/y delayed exactly BARY_LATENCY cycles.
- tri_done is asserted the cycle after DRAIN completes, so it never precedes the last pix_valid.
- Throughput: 1 pixel/cycle while unstalled. Per-triangle overhead = 3 + init time + BARY_LATENCY + 1 cycles.

## Configuration
- TRI_PIXEL_SCANNER_PERF_EN defined:
  - Adds output pix_count [31:0], the number of pixels issued for the current triangle.
  - Cleared on accept, frozen at DONE, reset to 0.
- Not defined: the port and the counter are absent. No other behaviour changes.

## Structure
- Package tri_scan_pkg holds:
  - coord_t (signed COORD_WIDTH/2) and vec3_t.
  - The state enum.
  - Default SCREEN_W, SCREEN_H and BARY_LATENCY constants.
- Sub-module pix_delay_line: a parameterised-depth shift register carrying {valid, x, y}, with synchronous clear.

## Test plan
- Triangle a=(10,10), b=(13,10), c=(10,12), init_done 5 cycles after init:
  - exactly 12 bary_valid, (10,10)…(13,12) in raster order;
  - pix_valid follows each by 13 cycles; one tri_done with tri_skipped=0.
- Triangle a=(-5,-5), b=(2,-5), c=(-5,1): box clamped to x 0..2, y 0..1 → 6 pixels, first (0,0).
- Triangle entirely at x≥400 → tri_done with tri_skipped=1 at T+2; bary_rst/bary_init never pulse.
- Collinear triangle, bary_init_failed pulsed in WAIT_INIT → tri_done with tri_skipped=1, zero bary_valid.
- stall_in high for 3 cycles mid-row → issue gap of 3 cycles; no pixel dropped or duplicated; pix_valid shows the same 3-cycle gap.
- rst_in asserted during SCAN:
  - next cycle bary_valid=0 and tri_ready=1; pix_valid stays 0;
  - no tri_done.
